// File: rtl/uart_pkg.sv
// Shared constants, state encoding and parity helper for the multimode UART receiver.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'd0;
  localparam logic [1:0] PARITY_EVEN = 2'd1;
  localparam logic [1:0] PARITY_ODD  = 2'd2;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } rx_state_e;

  // Expected parity bit for the given data; unused upper bits must be zero.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data,
                                      input logic [1:0]               mode);
    return (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous output FIFO; a push while full is accepted only if a pop frees a slot that cycle.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/uart_rx_multimode.sv
// UART receiver with configurable framing, 3-sample majority voting, output FIFO,
// per-word parity/frame flags, break and overrun pulses.
//
// state        | meaning
// ST_IDLE      | line idle, waiting for a low sample on a tick
// ST_START     | validating the start bit (voted 1 = false start)
// ST_DATA      | shifting in data bits, LSB first
// ST_PARITY    | capturing the parity bit
// ST_STOP      | checking stop bit(s); word pushed at last stop resolve
// ST_WAIT_IDLE | after a frame error, waiting for the line to return high
module uart_rx_multimode
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 UART_CLK_EN,
  input  logic                 UART_RXD,
  output logic [DATA_BITS-1:0] DATA_OUT,
  output logic                 DATA_VLD,
  input  logic                 DATA_RDY,
  output logic                 PARITY_ERROR,
  output logic                 FRAME_ERROR,
  output logic                 BREAK_DET,
  output logic                 OVERRUN_ERROR,
  output logic                 BUSY
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int FW = DATA_BITS + 2;

  rx_state_e               state;
  logic                    rxd_meta;
  logic                    rxd_sync;
  logic [TW-1:0]           tick_cnt;
  logic [TW-1:0]           tick_nxt;
  logic [3:0]              bit_cnt;
  logic [DATA_BITS-1:0]    shreg;
  logic                    samp_lo;
  logic                    samp_mid;
  logic                    par_bit;
  logic                    frame_err;
  logic                    vote;
  logic                    resolve;
  logic                    fe_final;
  logic                    par_err;
  logic                    push_now;
  logic                    brk_now;
  logic                    overrun_now;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [FW-1:0]           fifo_head;
  logic [MAX_DATA_BITS-1:0] data_ext;

  assign tick_nxt = (tick_cnt == TW'(OVERSAMPLE-1)) ? '0 : tick_cnt + TW'(1);
  assign vote     = (samp_lo & samp_mid) | (samp_lo & rxd_sync) | (samp_mid & rxd_sync);
  assign resolve  = UART_CLK_EN && (state != ST_IDLE) && (state != ST_WAIT_IDLE)
                    && (tick_nxt == TW'(M+1));
  assign fe_final = frame_err | ~vote;

  always_comb begin
    data_ext = '0;
    data_ext[DATA_BITS-1:0] = shreg;
  end

  assign par_err     = (PARITY_MODE != 0) && (par_bit != parity_bit(data_ext, 2'(PARITY_MODE)));
  assign push_now    = resolve && (state == ST_STOP) && (bit_cnt == 4'(STOP_BITS-1));
  assign brk_now     = push_now && fe_final && (shreg == '0) && ((PARITY_MODE == 0) || !par_bit);
  assign pop         = DATA_VLD & DATA_RDY;
  assign overrun_now = push_now & fifo_full & ~pop;

  uart_rx_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (push_now),
    .pop   (pop),
    .din   ({shreg, par_err, fe_final}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Head is masked while empty so the outputs read 0 without resetting the memory.
  assign DATA_VLD     = ~fifo_empty;
  assign DATA_OUT     = DATA_VLD ? fifo_head[FW-1:2] : '0;
  assign PARITY_ERROR = DATA_VLD & fifo_head[1];
  assign FRAME_ERROR  = DATA_VLD & fifo_head[0];
  assign BUSY         = (state != ST_IDLE);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= UART_RXD;
      rxd_sync <= rxd_meta;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= ST_IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      samp_lo       <= 1'b1;
      samp_mid      <= 1'b1;
      par_bit       <= 1'b0;
      frame_err     <= 1'b0;
      BREAK_DET     <= 1'b0;
      OVERRUN_ERROR <= 1'b0;
    end else begin
      BREAK_DET     <= brk_now;
      OVERRUN_ERROR <= overrun_now;
      if (UART_CLK_EN) begin
        case (state)
          ST_IDLE: begin
            if (!rxd_sync) begin
              state     <= ST_START;
              tick_cnt  <= '0;
              bit_cnt   <= '0;
              frame_err <= 1'b0;
            end
          end
          ST_WAIT_IDLE: begin
            if (rxd_sync) state <= ST_IDLE;
          end
          default: begin
            tick_cnt <= tick_nxt;
            if (tick_nxt == TW'(M-1)) samp_lo  <= rxd_sync;
            if (tick_nxt == TW'(M))   samp_mid <= rxd_sync;
            if (resolve) begin
              case (state)
                ST_START: begin
                  state   <= vote ? ST_IDLE : ST_DATA;
                  bit_cnt <= '0;
                end
                ST_DATA: begin
                  shreg <= {vote, shreg[DATA_BITS-1:1]};
                  if (bit_cnt == 4'(DATA_BITS-1)) begin
                    bit_cnt <= '0;
                    state   <= (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
                  end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                  end
                end
                ST_PARITY: begin
                  par_bit <= vote;
                  state   <= ST_STOP;
                end
                ST_STOP: begin
                  if (push_now) begin
                    state <= fe_final ? ST_WAIT_IDLE : ST_IDLE;
                  end else begin
                    frame_err <= fe_final;
                    bit_cnt   <= bit_cnt + 4'd1;
                  end
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_multimode.sv
// Directed bench: 8N1 receiver (dut_a) and even-parity receiver (dut_p), OVERSAMPLE 16, tick every 4 clocks.
module tb_uart_rx_multimode;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_clk_en;
  logic       rxd_a, rxd_p;
  logic       rdy_a, rdy_p;
  logic [7:0] dout_a, dout_p;
  logic       vld_a, vld_p, pe_a, pe_p, fe_a, fe_p;
  logic       brk_a, brk_p, ovr_a, ovr_p, busy_a, busy_p;

  int checks   = 0;
  int failures = 0;
  int brk_cnt_a = 0;
  int ovr_cnt_a = 0;
  logic [9:0] q_a[$];
  logic [9:0] q_p[$];

  always #5 clk = ~clk;

  initial begin
    uart_clk_en = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      uart_clk_en = 1'b1;
      @(negedge clk);
      uart_clk_en = 1'b0;
    end
  end

  uart_rx_multimode #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut_a (
    .CLK(clk), .RST_N(rst_n), .UART_CLK_EN(uart_clk_en), .UART_RXD(rxd_a),
    .DATA_OUT(dout_a), .DATA_VLD(vld_a), .DATA_RDY(rdy_a), .PARITY_ERROR(pe_a),
    .FRAME_ERROR(fe_a), .BREAK_DET(brk_a), .OVERRUN_ERROR(ovr_a), .BUSY(busy_a));

  uart_rx_multimode #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut_p (
    .CLK(clk), .RST_N(rst_n), .UART_CLK_EN(uart_clk_en), .UART_RXD(rxd_p),
    .DATA_OUT(dout_p), .DATA_VLD(vld_p), .DATA_RDY(rdy_p), .PARITY_ERROR(pe_p),
    .FRAME_ERROR(fe_p), .BREAK_DET(brk_p), .OVERRUN_ERROR(ovr_p), .BUSY(busy_p));

  // Records every accepted word and counts pulses, sampled on the falling edge.
  always @(negedge clk) begin
    if (vld_a && rdy_a) q_a.push_back({dout_a, pe_a, fe_a});
    if (vld_p && rdy_p) q_p.push_back({dout_p, pe_p, fe_p});
    if (brk_a) brk_cnt_a++;
    if (ovr_a) ovr_cnt_a++;
  end

  task automatic drive(input bit sel, input logic v, input int nclk);
    if (sel) rxd_p = v;
    else     rxd_a = v;
    repeat (nclk) @(negedge clk);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit has_par, input logic pbit);
    drive(sel, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive(sel, d[i], BIT_CLK);
    if (has_par) drive(sel, pbit, BIT_CLK);
    drive(sel, 1'b1, 2 * BIT_CLK);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (vld_a !== 1'b0) begin failures++; $display("FAIL reset_vld actual=%b required=0", vld_a); end
    checks++;
    if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy_a); end
    checks++;
    if (dout_a !== 8'h00) begin failures++; $display("FAIL reset_dout actual=%h required=00", dout_a); end
    checks++;
    if ({pe_a, fe_a, brk_a, ovr_a} !== 4'b0000)
      begin failures++; $display("FAIL reset_flags actual=%b required=0000", {pe_a, fe_a, brk_a, ovr_a}); end
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_8n1;
    int b0, o0;
    q_a.delete();
    b0 = brk_cnt_a;
    o0 = ovr_cnt_a;
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0);
    checks++;
    if (q_a.size() != 1) begin failures++; $display("FAIL 8n1_count actual=%0d required=1", q_a.size()); end
    checks++;
    if (q_a.size() == 0 || q_a[0] !== {8'hA5, 2'b00})
      begin failures++; $display("FAIL 8n1_word actual=%h required=%h", (q_a.size() > 0) ? q_a[0] : 10'h3ff, {8'hA5, 2'b00}); end
    checks++;
    if (brk_cnt_a != b0 || ovr_cnt_a != o0)
      begin failures++; $display("FAIL 8n1_pulses brk=%0d ovr=%0d required=0 0", brk_cnt_a - b0, ovr_cnt_a - o0); end
    checks++;
    if (busy_a !== 1'b0) begin failures++; $display("FAIL 8n1_busy actual=%b required=0", busy_a); end
  endtask

  task automatic test_parity;
    logic [7:0] d    [3] = '{8'h03, 8'h03, 8'h07};
    logic       pb   [3] = '{1'b1, 1'b0, 1'b1};
    logic [9:0] exp_w[3] = '{{8'h03, 2'b10}, {8'h03, 2'b00}, {8'h07, 2'b00}};
    for (int k = 0; k < 3; k++) begin
      q_p.delete();
      send_frame(1'b1, d[k], 1'b1, pb[k]);
      checks++;
      if (q_p.size() != 1 || q_p[0] !== exp_w[k])
        begin failures++; $display("FAIL parity_word%0d n=%0d actual=%h required=%h", k, q_p.size(), (q_p.size() > 0) ? q_p[0] : 10'h3ff, exp_w[k]); end
    end
  endtask

  task automatic test_break;
    int b0;
    q_a.delete();
    b0 = brk_cnt_a;
    drive(1'b0, 1'b0, 12 * BIT_CLK);
    checks++;
    if (q_a.size() != 1 || q_a[0] !== {8'h00, 2'b01})
      begin failures++; $display("FAIL break_word n=%0d actual=%h required=%h", q_a.size(), (q_a.size() > 0) ? q_a[0] : 10'h3ff, {8'h00, 2'b01}); end
    checks++;
    if (brk_cnt_a - b0 != 1) begin failures++; $display("FAIL break_pulse actual=%0d required=1", brk_cnt_a - b0); end
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL break_wait_busy actual=%b required=1", busy_a); end
    drive(1'b0, 1'b1, 3 * BIT_CLK);
    checks++;
    if (q_a.size() != 1) begin failures++; $display("FAIL break_second_word actual=%0d required=1", q_a.size()); end
    checks++;
    if (busy_a !== 1'b0) begin failures++; $display("FAIL break_idle_busy actual=%b required=0", busy_a); end
  endtask

  task automatic test_glitch;
    q_a.delete();
    drive(1'b0, 1'b0, 16);
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL glitch_start_busy actual=%b required=1", busy_a); end
    drive(1'b0, 1'b1, 64);
    checks++;
    if (busy_a !== 1'b0) begin failures++; $display("FAIL glitch_busy actual=%b required=0", busy_a); end
    drive(1'b0, 1'b1, 2 * BIT_CLK);
    checks++;
    if (q_a.size() != 0) begin failures++; $display("FAIL glitch_word actual=%0d required=0", q_a.size()); end
  endtask

  task automatic test_overrun;
    int o0;
    @(posedge clk); #1 rdy_a = 1'b0;
    q_a.delete();
    o0 = ovr_cnt_a;
    for (int k = 0; k < 5; k++) send_frame(1'b0, 8'(8'h11 + k), 1'b0, 1'b0);
    checks++;
    if (ovr_cnt_a - o0 != 1) begin failures++; $display("FAIL overrun_pulse actual=%0d required=1", ovr_cnt_a - o0); end
    checks++;
    if (vld_a !== 1'b1 || dout_a !== 8'h11)
      begin failures++; $display("FAIL overrun_head vld=%b actual=%h required=11", vld_a, dout_a); end
    repeat (10) @(negedge clk);
    checks++;
    if (dout_a !== 8'h11 || pe_a !== 1'b0 || fe_a !== 1'b0)
      begin failures++; $display("FAIL overrun_hold actual=%h required=11", dout_a); end
    @(posedge clk); #1 rdy_a = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (q_a.size() != 4) begin failures++; $display("FAIL overrun_count actual=%0d required=4", q_a.size()); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= q_a.size() || q_a[k] !== {8'(8'h11 + k), 2'b00})
        begin failures++; $display("FAIL overrun_order%0d actual=%h required=%h", k, (k < q_a.size()) ? q_a[k] : 10'h3ff, {8'(8'h11 + k), 2'b00}); end
    end
    checks++;
    if (vld_a !== 1'b0) begin failures++; $display("FAIL overrun_drained actual=%b required=0", vld_a); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d = 8'h5A;
    q_a.delete();
    drive(1'b0, 1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive(1'b0, d[i], BIT_CLK);
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL midrst_busy_before actual=%b required=1", busy_a); end
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, vld_a, dout_a, pe_a, fe_a, brk_a, ovr_a} !== 14'd0)
      begin failures++; $display("FAIL midrst_outputs busy=%b vld=%b dout=%h required=0", busy_a, vld_a, dout_a); end
    rxd_a = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b1, 2 * BIT_CLK);
    checks++;
    if (q_a.size() != 0) begin failures++; $display("FAIL midrst_word actual=%0d required=0", q_a.size()); end
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0);
    checks++;
    if (q_a.size() != 1 || q_a[0] !== {8'h3C, 2'b00})
      begin failures++; $display("FAIL midrst_next n=%0d actual=%h required=%h", q_a.size(), (q_a.size() > 0) ? q_a[0] : 10'h3ff, {8'h3C, 2'b00}); end
  endtask

  initial begin
    rxd_a = 1'b1;
    rxd_p = 1'b1;
    rdy_a = 1'b1;
    rdy_p = 1'b1;
    test_reset();
    test_8n1();
    test_parity();
    test_break();
    test_glitch();
    test_overrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
